// File: rtl/pulse_chk_pkg.sv
// pulse_chk_pkg: shared types and defaults for the pulse width checker.
// Provides the FSM state encoding and default parameter values.
package pulse_chk_pkg;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam int EXP_W_DEF = 12;
   localparam int CW_DEF    = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear-then-increment semantics.
// Ports: clk, rstb (async low), inc, clr, cnt[W-1:0].
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // A clear on the same edge as an increment leaves the count at one.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = inc ? W'(1) : '0;
      end else if (inc && cnt_q != MAX) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pulse_width_checker.sv
// pulse_width_checker: measures high width of pulse_in, classifies it
// against EXP_W, keeps ok/err statistics. Ports: clk, rstb, pulse_in,
// chk_en, clr_stats in; busy, done, width, ok, short_err, long_err,
// ok_cnt, err_cnt out.
module pulse_width_checker
   import pulse_chk_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int CW    = CW_DEF,
   parameter int SW    = 8
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          pulse_in,
   input  logic          chk_en,
   input  logic          clr_stats,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] width,
   output logic          ok,
   output logic          short_err,
   output logic          long_err,
   output logic [SW-1:0] ok_cnt,
   output logic [SW-1:0] err_cnt
);

   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] EXP  = CW'(EXP_W);

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          capture;

   logic          done_q;
   logic [CW-1:0] width_q;
   logic          ok_q;
   logic          short_q;
   logic          long_q;

   logic          is_ok;
   logic          is_short;
   logic          is_long;

   // Disable wins over every state and throws away a partial measurement.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!chk_en) begin
         state_d = ARM;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ARM: begin
               if (!pulse_in) state_d = IDLE;
            end
            IDLE: begin
               if (pulse_in) begin
                  state_d = MEAS;
                  cnt_d   = CW'(1);
               end
            end
            MEAS: begin
               if (pulse_in) begin
                  if (cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
               end else begin
                  state_d = IDLE;
                  capture = 1'b1;
               end
            end
            default: begin
               state_d = ARM;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ARM;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign is_ok    = (cnt_q == EXP);
   assign is_short = (cnt_q < EXP);
   assign is_long  = (cnt_q > EXP);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         done_q  <= 1'b0;
         width_q <= '0;
         ok_q    <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         done_q <= capture;
         if (capture) begin
            width_q <= cnt_q;
            ok_q    <= is_ok;
            short_q <= is_short;
            long_q  <= is_long;
         end
      end
   end

   sat_counter #(.W(SW)) u_ok_cnt (
      .clk  (clk),
      .rstb (rstb),
      .inc  (capture & is_ok),
      .clr  (clr_stats),
      .cnt  (ok_cnt)
   );

   sat_counter #(.W(SW)) u_err_cnt (
      .clk  (clk),
      .rstb (rstb),
      .inc  (capture & ~is_ok),
      .clr  (clr_stats),
      .cnt  (err_cnt)
   );

   assign busy      = (state_q == MEAS);
   assign done      = done_q;
   assign width     = width_q;
   assign ok        = ok_q;
   assign short_err = short_q;
   assign long_err  = long_q;

endmodule

// File: tb/tb_pulse_width_checker.sv
// tb_pulse_width_checker: randomized pulse stimulus checked against a
// pulse-level model of widths, classes and statistics.
module tb_pulse_width_checker;

   localparam int EXP_W = 12;
   localparam int CW    = 4;
   localparam int SW    = 8;
   localparam int WMAX  = 15;
   localparam int SMAX  = 255;

   logic          clk = 1'b0;
   logic          rstb;
   logic          pulse_in;
   logic          chk_en;
   logic          clr_stats;
   logic          busy;
   logic          done;
   logic [CW-1:0] width;
   logic          ok;
   logic          short_err;
   logic          long_err;
   logic [SW-1:0] ok_cnt;
   logic [SW-1:0] err_cnt;

   pulse_width_checker #(
      .EXP_W (EXP_W),
      .CW    (CW),
      .SW    (SW)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .pulse_in  (pulse_in),
      .chk_en    (chk_en),
      .clr_stats (clr_stats),
      .busy      (busy),
      .done      (done),
      .width     (width),
      .ok        (ok),
      .short_err (short_err),
      .long_err  (long_err),
      .ok_cnt    (ok_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int got_dones = 0;
   int exp_dones = 0;

   int m_ok, m_err, m_w;
   bit m_okf, m_s, m_l;

   always @(negedge clk)
      if (rstb === 1'b1 && done === 1'b1) got_dones++;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_ok = 0; m_err = 0; m_w = 0;
      m_okf = 0; m_s = 0; m_l = 0;
   endtask

   task automatic check_res(input string tag);
      check({tag, "_w"}, 32'(width), 32'(m_w));
      check({tag, "_ok"}, 32'(ok), 32'(m_okf));
      check({tag, "_sh"}, 32'(short_err), 32'(m_s));
      check({tag, "_lg"}, 32'(long_err), 32'(m_l));
      check({tag, "_okc"}, 32'(ok_cnt), 32'(m_ok));
      check({tag, "_erc"}, 32'(err_cnt), 32'(m_err));
   endtask

   // n high cycles, then gap low cycles; abort_at drops chk_en for one
   // high cycle (-1 = none); clr pulses clr_stats on the capture edge.
   task automatic drive_pulse(input int n, input int gap,
                              input int abort_at, input bit clr);
      bit ab = (abort_at >= 0);
      int w;
      for (int i = 0; i < n; i++) begin
         pulse_in = 1'b1;
         chk_en   = (i == abort_at) ? 1'b0 : 1'b1;
         tick();
         if (!ab) check("busy_hi", 32'(busy), 1);
         else if (i >= abort_at) check("busy_ab", 32'(busy), 0);
         check("done_hi", 32'(done), 0);
      end
      chk_en    = 1'b1;
      pulse_in  = 1'b0;
      clr_stats = clr;
      tick();
      clr_stats = 1'b0;
      if (clr) begin
         m_ok = 0;
         m_err = 0;
      end
      if (!ab) begin
         w = (n > WMAX) ? WMAX : n;
         m_w = w;
         m_okf = (w == EXP_W);
         m_s = (w < EXP_W);
         m_l = (w > EXP_W);
         if (m_okf) m_ok = (m_ok < SMAX) ? m_ok + 1 : SMAX;
         else m_err = (m_err < SMAX) ? m_err + 1 : SMAX;
         exp_dones++;
      end
      check("done_cap", 32'(done), 32'(!ab));
      check("busy_lo", 32'(busy), 0);
      check_res("cap");
      for (int j = 1; j < gap; j++) begin
         tick();
         check("done_gap", 32'(done), 0);
      end
   endtask

   task automatic do_reset(input logic p);
      rstb = 1'b0;
      pulse_in = p;
      chk_en = 1'b1;
      clr_stats = 1'b0;
      repeat (2) tick();
      model_reset();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check_res("rst");
      rstb = 1'b1;
   endtask

   int d0, n, gap, ab;

   initial begin
      model_reset();
      do_reset(1'b0);
      tick();

      drive_pulse(12, 2, -1, 0);
      check("good_w", 32'(width), 12);
      check("good_ok", 32'(ok), 1);
      drive_pulse(11, 2, -1, 0);
      check("short_w", 32'(width), 11);
      check("short_f", 32'(short_err), 1);
      drive_pulse(20, 2, -1, 0);
      check("long_w", 32'(width), 15);
      check("long_f", 32'(long_err), 1);
      check("long_erc", 32'(err_cnt), 2);

      d0 = got_dones;
      drive_pulse(12, 2, 5, 0);
      check("abort_nodone", 32'(got_dones - d0), 0);
      check("abort_w", 32'(width), 15);

      do_reset(1'b1);
      repeat (5) begin
         tick();
         check("hr_busy", 32'(busy), 0);
         check("hr_done", 32'(done), 0);
      end
      pulse_in = 1'b0;
      tick();
      check_res("hr_idle");
      drive_pulse(12, 1, -1, 0);
      check("hr_ok", 32'(ok), 1);

      drive_pulse(12, 1, -1, 1);
      repeat (4) drive_pulse(12, 1, -1, 0);
      check("pre_coll", 32'(ok_cnt), 5);
      drive_pulse(12, 1, -1, 1);
      check("coll_ok", 32'(ok_cnt), 1);
      check("coll_err", 32'(err_cnt), 0);

      d0 = got_dones;
      repeat (300) drive_pulse(12, 1, -1, 0);
      check("b2b_dones", 32'(got_dones - d0), 300);
      check("sat_ok", 32'(ok_cnt), 255);

      repeat (150) begin
         n = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 14)
                                         : $urandom_range(1, 20);
         gap = $urandom_range(1, 3);
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
         drive_pulse(n, gap, ab, ($urandom_range(0, 9) == 0));
      end

      pulse_in = 1'b1;
      repeat (6) tick();
      check("mr_busy", 32'(busy), 1);
      #2 rstb = 1'b0;
      #1;
      model_reset();
      check("mr_busy0", 32'(busy), 0);
      check("mr_done0", 32'(done), 0);
      check_res("mr");
      repeat (2) tick();
      rstb = 1'b1;
      repeat (4) begin
         tick();
         check("mr_arm", 32'(busy), 0);
      end
      pulse_in = 1'b0;
      tick();
      drive_pulse(12, 1, -1, 0);
      check("mr_ok", 32'(ok), 1);

      tick();
      check("done_total", 32'(got_dones), 32'(exp_dones));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
